// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: four-digit BCD display scanner with frame-aligned value swap; optional leading-zero blanking via DISPLAY_SCAN_LZB_EN
module display_scan_ctrl #(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic [15:0] val,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic [3:0]  dig_n,
  output logic        frame,
  output logic        pend,
  output logic        err
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt;
  logic [1:0]   idx;
  logic [15:0]  shadow, active;
  logic [3:0]   nib;
  logic         tick, wrap, blank;
  assign tick = cnt == W'(DIV - 1);
  assign wrap = tick && idx == 2'd3;
  // prescaler steps the digit index once per slot
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + W'(1);
      idx <= tick ? idx + 2'd1 : idx;
    end
  // new values wait in shadow and swap in only at the wrap so a frame never mixes two values
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shadow <= '0;
      active <= '0;
      pend   <= 1'b0;
      frame  <= 1'b0;
    end else begin
      if (ld) shadow <= val;
      if (wrap) active <= ld ? val : pend ? shadow : active;
      pend  <= wrap ? 1'b0 : (ld | pend);
      frame <= wrap;
    end
  // select the nibble for the current digit slot
  always_comb
    nib = idx == 2'd0 ? active[3:0] : idx == 2'd1 ? active[7:4] : idx == 2'd2 ? active[11:8] : active[15:12];
`ifdef DISPLAY_SCAN_LZB_EN
  logic z3, z2, z1;
  assign z3    = active[15:12] == 4'd0;
  assign z2    = z3 && active[11:8] == 4'd0;
  assign z1    = z2 && active[7:4] == 4'd0;
  assign blank = idx == 2'd3 ? z3 : idx == 2'd2 ? z2 : idx == 2'd1 ? z1 : 1'b0;
`else
  assign blank = 1'b0;
`endif
  assign err          = nib > 4'd9;
  assign {a, b, c, d} = (err | blank) ? 4'hF : nib;
  assign dig_n        = cnt == '0 ? 4'hF : ~(4'b0001 << idx);
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench for display_scan_ctrl with DIV=4
module tb_display_scan_ctrl;
  logic        clk = 1'b0, rst = 1'b1, ld = 1'b0;
  logic [15:0] val = '0;
  logic        a, b, c, d, frame, pend, err;
  logic [3:0]  dig_n, abcd;
  typedef struct {logic [3:0] nib; logic [3:0] dn; logic er; logic fr;} exp_t;
  exp_t        sb[$];
  int          total = 0, bad = 0, cyc = 0;
  logic [15:0] m_active = '0, m_shadow = '0;
  logic        m_pend = 1'b0;
  display_scan_ctrl #(.DIV(4)) dut (
    .clk(clk), .rst(rst), .ld(ld), .val(val),
    .a(a), .b(b), .c(c), .d(d),
    .dig_n(dig_n), .frame(frame), .pend(pend), .err(err)
  );
  assign abcd = {a, b, c, d};
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic align();
    do step(); while (cyc % 16 != 0);
  endtask
  function automatic logic [3:0] dnib(input logic [15:0] v, input int s);
    return v[4*s +: 4];
  endfunction
  function automatic logic [3:0] exp_out(input logic [15:0] v, input int s);
    logic [3:0] n = dnib(v, s);
    logic bl = 1'b0;
`ifdef DISPLAY_SCAN_LZB_EN
    bl = s != 0 && (v >> (4 * s)) == 16'd0;
`endif
    return (n > 4'd9 || bl) ? 4'hF : n;
  endfunction
  task automatic check_frame(input int l1, input logic [15:0] v1, input int l2, input logic [15:0] v2);
    exp_t e;
    logic [3:0] one = 4'b0001;
    logic ldd;
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 4; k++) begin
        e.nib = exp_out(m_active, s);
        e.er  = dnib(m_active, s) > 4'd9;
        e.dn  = k == 0 ? 4'hF : ~(one << s);
        e.fr  = s == 0 && k == 0 && cyc != 0;
        sb.push_back(e);
      end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty at cyc=%0d", cyc);
      end else begin
        e = sb.pop_front();
        total += 3;
        if (abcd !== e.nib) begin bad++; $display("FAIL nibble cyc=%0d got=%h exp=%h", cyc, abcd, e.nib); end
        if (dig_n !== e.dn) begin bad++; $display("FAIL dig_n cyc=%0d got=%b exp=%b", cyc, dig_n, e.dn); end
        if (err !== e.er) begin bad++; $display("FAIL err cyc=%0d got=%b exp=%b", cyc, err, e.er); end
        if (frame !== e.fr) begin bad++; $display("FAIL frame cyc=%0d got=%b exp=%b", cyc, frame, e.fr); end
      end
      if (pend !== m_pend) begin bad++; $display("FAIL pend cyc=%0d got=%b exp=%b", cyc, pend, m_pend); end
      ldd = i == l1 || i == l2;
      ld  = ldd;
      val = i == l1 ? v1 : v2;
      step();
      ld = 1'b0;
      if (ldd) m_shadow = val;
      if (i == 15) begin
        if (ldd) m_active = val;
        else if (m_pend) m_active = m_shadow;
        m_pend = 1'b0;
      end else if (ldd) m_pend = 1'b1;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total += 3;
    if (dig_n !== 4'hF) begin bad++; $display("FAIL rst_dig_n got=%b exp=1111", dig_n); end
    if (abcd !== 4'h0) begin bad++; $display("FAIL rst_nibble got=%h exp=0", abcd); end
    if ({pend, err, frame} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {pend, err, frame}); end
    rst = 1'b0;
    cyc = 0;
    total += 2;
    if (dig_n !== 4'hF) begin bad++; $display("FAIL rel0_dig_n got=%b exp=1111", dig_n); end
    if (frame !== 1'b0) begin bad++; $display("FAIL rel0_frame got=%b exp=0", frame); end
    step();
    total += 3;
    if (dig_n !== 4'b1110) begin bad++; $display("FAIL rel1_dig_n got=%b exp=1110", dig_n); end
    if (abcd !== 4'h0) begin bad++; $display("FAIL rel1_nibble got=%h exp=0", abcd); end
    if (frame !== 1'b0) begin bad++; $display("FAIL rel1_frame got=%b exp=0", frame); end
    m_active = '0; m_shadow = '0; m_pend = 1'b0;
    align();
  endtask
  task automatic test_scan_load();
    check_frame(2, 16'h1234, -1, '0);
    check_frame(-1, '0, -1, '0);
    check_frame(-1, '0, -1, '0);
  endtask
  task automatic test_simultaneous();
    check_frame(15, 16'h5678, -1, '0);
    total += 3;
    if (abcd !== 4'h8) begin bad++; $display("FAIL simul_nibble got=%h exp=8", abcd); end
    if (pend !== 1'b0) begin bad++; $display("FAIL simul_pend got=%b exp=0", pend); end
    if (dig_n !== 4'hF) begin bad++; $display("FAIL simul_dig_n got=%b exp=1111", dig_n); end
    check_frame(-1, '0, -1, '0);
  endtask
  task automatic test_back_to_back();
    check_frame(3, 16'h1111, 9, 16'h2222);
    check_frame(-1, '0, -1, '0);
  endtask
  task automatic test_nonbcd();
    check_frame(1, 16'h00A9, -1, '0);
    check_frame(-1, '0, -1, '0);
  endtask
  task automatic test_lzb();
    check_frame(1, 16'h0045, -1, '0);
    check_frame(-1, '0, -1, '0);
    check_frame(1, 16'h0000, -1, '0);
    check_frame(-1, '0, -1, '0);
  endtask
  task automatic test_reset_mid();
    check_frame(1, 16'h1234, -1, '0);
    repeat (5) step();
    ld  = 1'b1;
    val = 16'h9999;
    step();
    ld = 1'b0;
    total += 3;
    if (abcd !== 4'h3) begin bad++; $display("FAIL mid_nibble got=%h exp=3", abcd); end
    if (pend !== 1'b1) begin bad++; $display("FAIL mid_pend got=%b exp=1", pend); end
    if (dig_n !== 4'b1101) begin bad++; $display("FAIL mid_dig_n got=%b exp=1101", dig_n); end
    rst = 1'b1;
    #1;
    total += 3;
    if (dig_n !== 4'hF) begin bad++; $display("FAIL async_dig_n got=%b exp=1111", dig_n); end
    if (abcd !== 4'h0) begin bad++; $display("FAIL async_nibble got=%h exp=0", abcd); end
    if ({pend, err, frame} !== 3'b000) begin bad++; $display("FAIL async_flags got=%b exp=000", {pend, err, frame}); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    step();
    total += 3;
    if (dig_n !== 4'b1110) begin bad++; $display("FAIL mid_rel_dig_n got=%b exp=1110", dig_n); end
    if (abcd !== 4'h0) begin bad++; $display("FAIL mid_rel_nibble got=%h exp=0", abcd); end
    if (pend !== 1'b0) begin bad++; $display("FAIL mid_rel_pend got=%b exp=0", pend); end
    m_active = '0; m_shadow = '0; m_pend = 1'b0;
    align();
    check_frame(-1, '0, -1, '0);
  endtask
  initial begin
    test_reset();
    test_scan_load();
    test_simultaneous();
    test_back_to_back();
    test_nonbcd();
    test_lzb();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
